// File: rtl/rr_selector_arbiter_pkg.sv
// Shared constants for the round-robin selector arbiter: FSM encoding,
// default geometry and the active-low selector enable levels.
package rr_selector_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  localparam int SEL_W_DEF = 5;
  localparam int N_REQ_DEF = 32;

  localparam logic ENA_ON  = 1'b0;
  localparam logic ENA_OFF = 1'b1;

endpackage

// File: rtl/rr_selector_arbiter_pick.sv
// Rotating-priority search: first requester after i_ptr, wrapping around
// so that i_ptr itself has the lowest priority.
module rr_priority_pick
  import rr_selector_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [SEL_W-1:0] i_ptr,
  output logic [SEL_W-1:0] o_winner,
  output logic             o_any
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [SEL_W:0]     w_shift;
  logic [SEL_W-1:0]   w_off;

  always_comb begin
    // Shift by ptr+1 (up to N_REQ), so bit 0 of w_rot is requester ptr+1.
    w_shift = {1'b0, i_ptr} + {{SEL_W{1'b0}}, 1'b1};
    w_dbl   = {i_req, i_req} >> w_shift;
    w_rot   = w_dbl[N_REQ-1:0];
    w_off   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = SEL_W'(i);
    end
    // Modulo N_REQ comes for free from SEL_W-bit truncation.
    o_winner = i_ptr + SEL_W'(1) + w_off;
    o_any    = |i_req;
  end

endmodule

// File: rtl/rr_selector_arbiter.sv
// Round-robin arbiter that grants the 32:1 word selector to one requester
// at a time and bursts up to MAX_BURST beats over a valid/ready handshake.
module rr_selector_arbiter
  import rr_selector_arbiter_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int SEL_W     = SEL_W_DEF,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] iReq,
  input  logic             iReady,
  output logic [SEL_W-1:0] oControl,
  output logic             oEna,
  output logic [N_REQ-1:0] oGrant,
  output logic             oValid,
  output logic             oLast,
  output state_e           oDbgState
);

  // Handshake: a beat transfers on a rising edge where oValid and iReady are
  // both high; oValid follows the grantee's request, and iReady may stay low
  // indefinitely without losing the grant.

  state_e           r_state;
  logic [SEL_W-1:0] r_cur;
  logic [SEL_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_beat_cnt;

  logic [SEL_W-1:0] w_winner;
  logic             w_any;
  logic             w_xfer;
  logic             w_valid;
  logic             w_beat;
  logic             w_cnt_last;
  logic             w_end;
  logic [N_REQ-1:0] w_grant;

  rr_priority_pick #(
    .N_REQ(N_REQ),
    .SEL_W(SEL_W)
  ) u_pick (
    .i_req   (iReq),
    .i_ptr   (r_ptr),
    .o_winner(w_winner),
    .o_any   (w_any)
  );

  always_comb begin
    w_xfer     = (r_state == ST_XFER);
    w_valid    = w_xfer & iReq[r_cur];
    w_beat     = w_valid & iReady;
    w_cnt_last = (r_beat_cnt == CNT_W'(MAX_BURST - 1));
    // A withdrawn request ends the burst even if iReady is high.
    w_end      = w_xfer & ((w_beat & w_cnt_last) | ~iReq[r_cur]);
    w_grant    = '0;
    if (w_xfer) w_grant[r_cur] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cur      <= '0;
      r_ptr      <= SEL_W'(N_REQ - 1);
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_cur      <= w_winner;
            r_ptr      <= w_winner;
            r_beat_cnt <= '0;
            r_state    <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (w_end) begin
            // ptr already equals cur, so the outgoing grantee ranks last.
            if (w_any) begin
              r_cur      <= w_winner;
              r_ptr      <= w_winner;
              r_beat_cnt <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign oControl  = r_cur;
  assign oEna      = w_xfer ? ENA_ON : ENA_OFF;
  assign oGrant    = w_grant;
  assign oValid    = w_valid;
  assign oLast     = w_valid & w_cnt_last;
  assign oDbgState = r_state;

endmodule

// File: tb/tb_rr_selector_arbiter.sv
// Bench for rr_selector_arbiter: hand-computed vector table, directed
// corner sequences, then random traffic against a cycle reference model.
module tb_rr_selector_arbiter;
  import rr_selector_arbiter_pkg::*;

  localparam int N  = 32;
  localparam int MB = 4;
  localparam int W  = 40;  // {ctrl[5], ena, grant[32], valid, last}

  logic         clk;
  logic         rst;
  logic [N-1:0] iReq;
  logic         iReady;
  logic [4:0]   oControl;
  logic         oEna;
  logic [N-1:0] oGrant;
  logic         oValid;
  logic         oLast;
  state_e       oDbgState;

  int n_checks;
  int n_err;

  logic [W-1:0] exp_q[$];

  // reference model state
  bit m_known;
  bit m_xfer;
  int m_cur;
  int m_ptr;
  int m_cnt;

  typedef struct {
    logic         r;
    logic [N-1:0] req;
    logic         rdy;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  rr_selector_arbiter #(
    .N_REQ(32), .SEL_W(5), .MAX_BURST(MB), .CNT_W(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .iReq     (iReq),
    .iReady   (iReady),
    .oControl (oControl),
    .oEna     (oEna),
    .oGrant   (oGrant),
    .oValid   (oValid),
    .oLast    (oLast),
    .oDbgState(oDbgState)
  );

  function automatic logic [W-1:0] pack(int ctrl, logic ena, logic [N-1:0] g, logic v, logic l);
    return {5'(ctrl), ena, g, v, l};
  endfunction

  function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  function automatic int m_winner(logic [N-1:0] q, int p);
    for (int k = 1; k <= N; k++) if (q[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] model_out(logic [N-1:0] q);
    logic [N-1:0] g;
    logic v;
    g = '0;
    if (m_xfer) g[m_cur] = 1'b1;
    v = m_xfer && q[m_cur];
    return pack(m_cur, !m_xfer, g, v, v && (m_cnt == MB - 1));
  endfunction

  function automatic void model_edge(logic r, logic [N-1:0] q, logic rdy);
    bit beat;
    int w;
    if (r) begin
      m_known = 1; m_xfer = 0; m_cur = 0; m_ptr = N - 1; m_cnt = 0;
      return;
    end
    w = m_winner(q, m_ptr);
    if (!m_xfer) begin
      if (q != 0) begin m_cur = w; m_ptr = w; m_cnt = 0; m_xfer = 1; end
      return;
    end
    beat = q[m_cur] && rdy;
    if (!q[m_cur] || (beat && m_cnt == MB - 1)) begin
      if (q != 0) begin m_cur = w; m_ptr = w; m_cnt = 0; end
      else m_xfer = 0;
    end else if (beat) begin
      m_cnt++;
    end
  endfunction

  // ---------------- driver ----------------
  task automatic cycle(input logic r, input logic [N-1:0] q, input logic rdy,
                       output logic [W-1:0] act);
    @(negedge clk);
    rst = r; iReq = q; iReady = rdy;
    #1;
    act = {oControl, oEna, oGrant, oValid, oLast};
    if (m_known) begin
      exp_q.push_back(model_out(q));
      check("model", act, exp_q.pop_front());
    end
    @(posedge clk);
    model_edge(r, q, rdy);
  endtask

  task automatic do_reset();
    logic [W-1:0] a;
    cycle(1'b1, '0, 1'b0, a);
    cycle(1'b1, '0, 1'b0, a);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] a;
    int order[$];
    int cnt, held, last_at;
    int exp_order[6];

    n_checks = 0; n_err = 0; m_known = 0;
    m_xfer = 0; m_cur = 0; m_ptr = N - 1; m_cnt = 0;
    rst = 1'b1; iReq = '0; iReady = 1'b0;

    // reset then idle, then a single burst to requester 3
    vecs.push_back('{1'b1, 32'h0, 1'b0, pack(0, 1, 0, 0, 0)});
    vecs.push_back('{1'b0, 32'h0, 1'b1, pack(0, 1, 0, 0, 0)});
    vecs.push_back('{1'b0, 32'h8, 1'b1, pack(0, 1, 0, 0, 0)});
    vecs.push_back('{1'b0, 32'h8, 1'b1, pack(3, 0, 32'h8, 1, 0)});
    vecs.push_back('{1'b0, 32'h8, 1'b1, pack(3, 0, 32'h8, 1, 0)});
    vecs.push_back('{1'b0, 32'h8, 1'b1, pack(3, 0, 32'h8, 1, 0)});
    vecs.push_back('{1'b0, 32'h8, 1'b1, pack(3, 0, 32'h8, 1, 1)});
    vecs.push_back('{1'b0, 32'h8, 1'b1, pack(3, 0, 32'h8, 1, 0)});
    vecs.push_back('{1'b0, 32'h0, 1'b1, pack(3, 0, 32'h8, 0, 0)});
    vecs.push_back('{1'b0, 32'h0, 1'b1, pack(3, 1, 32'h0, 0, 0)});

    do_reset();
    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].req, vecs[i].rdy, a);
      check($sformatf("vec%0d", i), a, vecs[i].exp);
    end

    // round-robin fairness: 0,1,31 repeating
    do_reset();
    exp_order = '{0, 1, 31, 0, 1, 31};
    for (int c = 0; c < 25; c++) begin
      cycle(1'b0, 32'h8000_0003, 1'b1, a);
      if (a[1] && a[0]) order.push_back(int'(a[39:35]));
    end
    check("rr_count", W'(order.size()), W'(6));
    for (int k = 0; k < 6 && k < order.size(); k++)
      check($sformatf("rr_order%0d", k), W'(order[k]), W'(exp_order[k]));

    // backpressure from the first beat of a burst to requester 5
    do_reset();
    cycle(1'b0, 32'h20, 1'b1, a);
    held = 0;
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, 32'h20, 1'b0, a);
      if (a[39:35] == 5'd5 && !a[34] && a[1]) held++;
    end
    check("bp_held", W'(held), W'(6));
    cnt = 0; last_at = -1;
    for (int c = 0; c < 4; c++) begin
      cycle(1'b0, 32'h20, 1'b1, a);
      if (a[1]) cnt++;
      if (a[0]) last_at = c;
    end
    check("bp_beats", W'(cnt), W'(4));
    check("bp_last", W'(last_at), W'(3));

    // withdrawal of requester 7 after two beats, requester 9 waiting
    do_reset();
    cycle(1'b0, 32'h280, 1'b1, a);
    cnt = 0;
    for (int c = 0; c < 2; c++) begin
      cycle(1'b0, 32'h280, 1'b1, a);
      if (a[1] && a[39:35] == 5'd7) cnt++;
    end
    cycle(1'b0, 32'h200, 1'b1, a);
    if (a[1] && a[39:35] == 5'd7) cnt++;
    check("wd_beats7", W'(cnt), W'(2));
    cycle(1'b0, 32'h200, 1'b1, a);
    check("wd_ctrl9", W'(a[39:35]), W'(9));

    // reset in the middle of a burst to requester 12
    do_reset();
    cycle(1'b0, 32'h1000, 1'b1, a);
    cycle(1'b0, 32'h1000, 1'b1, a);
    cycle(1'b0, 32'h1000, 1'b1, a);
    cycle(1'b1, 32'h1000, 1'b1, a);
    cycle(1'b0, 32'h1000, 1'b1, a);
    check("rst_idle", {a[34], a[33:2]}, {1'b1, 32'h0});
    cnt = 0; last_at = -1;
    for (int c = 0; c < 4; c++) begin
      cycle(1'b0, 32'h1000, 1'b1, a);
      if (a[1] && a[39:35] == 5'd12) cnt++;
      if (a[0]) last_at = c;
    end
    check("rst_beats", W'(cnt), W'(4));
    check("rst_last", W'(last_at), W'(3));

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] q;
      case ($urandom_range(0, 3))
        0: q = '0;
        1: q = N'(1) << $urandom_range(0, N - 1);
        2: q = $urandom & $urandom & $urandom;
        default: q = $urandom;
      endcase
      cycle(($urandom_range(0, 199) == 0), q, ($urandom_range(0, 3) != 0), a);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rr_selector_arbiter.md
Name: rr_selector_arbiter

Overview:
- Round-robin arbiter and sequencer for the 32-input, 32-bit word selector (5-bit Control, active-low enable).
- Shares the selector output bus among up to 32 requesters.
- Grants one requester at a time, drives the selector's Control/enable, and bursts up to MAX_BURST words to a single downstream consumer over a valid/ready handshake.
- Sits between the requesting sources and the selector, one level above the datapath.

Parameters:
- N_REQ, 32, number of requesters; must equal 2**SEL_W.
- SEL_W, 5, width of the selector Control field.
- MAX_BURST, 4, maximum accepted beats per grant; legal range 1..16.
- CNT_W, 4, width of the beat counter; must satisfy 2**CNT_W >= MAX_BURST.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- iReq  in  N_REQ  request vector; bit i high = requester i has a word on selector input iCi.
- iReady  in  1  downstream consumer accepts the word on the selector output this cycle.
- oControl  out  SEL_W  selector Control; index of the current grantee.
- oEna  out  1  selector enable, active-low; 0 = selector drives the granted input.
- oGrant  out  N_REQ  one-hot grant to the current requester; all zeros when idle.
- oValid  out  1  selector output holds a valid word.
- oLast  out  1  the current beat is the final beat of the burst.

Behaviour:
- States: IDLE, XFER. Registers: state, cur (SEL_W), ptr (SEL_W, last granted index), beat_cnt (CNT_W).
- Reset (rst high at an edge):
  - state=IDLE, cur=0, ptr=N_REQ-1, beat_cnt=0.
  - Outputs: oControl=0, oEna=1, oGrant=0, oValid=0, oLast=0.
  - rst overrides everything, including a burst in progress; no beat is counted on the reset edge.
- Winner function (combinational): first i with iReq[i]=1, searching ptr+1, ptr+2, ... modulo N_REQ and wrapping through ptr itself last.
- IDLE:
  - oEna=1, oValid=0, oGrant=0.
  - If iReq != 0 at the edge: cur<=winner, ptr<=winner, beat_cnt<=0, state<=XFER.
  - Grant latency is 1 cycle from request to oGrant/oEna=0.
- XFER:
  - oControl=cur, oEna=0, oGrant=one-hot(cur).
  - oValid = iReq[cur] (combinational).
  - beat = oValid & iReady.
  - oLast = oValid & (beat_cnt == MAX_BURST-1).
- End of burst at an edge occurs when either:
  - beat & (beat_cnt == MAX_BURST-1), or
  - iReq[cur] == 0 (requester withdrew; no beat that cycle).
- At end of burst:
  - If iReq != 0: immediately re-arbitrate with the same winner function (ptr already = cur, so cur has lowest priority). cur/ptr <= winner, beat_cnt <= 0, stay in XFER. Gives back-to-back grants with no idle cycle.
  - Else: state <= IDLE; oEna returns to 1 the next cycle.
- Otherwise, on a beat: beat_cnt <= beat_cnt+1.
- Otherwise (no beat): hold all state. Backpressure via iReady=0 may last indefinitely; the grant is held.
- Withdrawal with iReady high in the same cycle: no beat is counted.
- A sole requester holding iReq high receives consecutive bursts of MAX_BURST beats each, with no gap.
- MAX_BURST=1: every beat ends the burst; oLast=oValid.
- Wrap-around: ptr=31 searches from index 0.
- oControl holds its last value in IDLE; it is only meaningful while oEna=0.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=1'b0, ST_XFER=1'b1;
  - SEL_W and N_REQ defaults;
  - the active-low enable constants ENA_ON=1'b0, ENA_OFF=1'b1.
- One sub-module, rr_priority_pick: combinational rotating-priority search.
  - Inputs: iReq, ptr. Outputs: winner index, any-request flag.
  - Implemented as a double-width vector shifted right by ptr+1, then a priority encoder.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, iReq=0 -> oEna=1, oGrant=0, oValid=0, oControl=0 throughout.
- Single burst:
  - Stimulus: iReq=32'h0000_0008, iReady=1.
  - Response: 1 cycle later oControl=3, oEna=0, oGrant=32'h8; 4 beats with oLast on the 4th.
  - Because iReq stays high, a new burst to requester 3 follows with no gap; drop iReq to end the sequence.
- Round-robin fairness:
  - Stimulus: iReq=32'h8000_0003 held, iReady=1.
  - Response: grant order 0,1,31,0,1,31, each burst exactly 4 beats with back-to-back handoff.
- Backpressure: during a burst to requester 5, iReady=0 for 6 cycles -> oValid=1, beat_cnt frozen, grant held; completes 4 beats after iReady returns.
- Withdrawal: requester 7 drops iReq after 2 beats while iReq[9]=1 -> at that edge oControl becomes 9; requester 7 gets no third beat.
- Reset mid-burst: rst=1 after beat 2 of requester 12 -> next cycle IDLE; after release with iReq=32'h1000, a fresh grant to 12 runs a full 4-beat burst.
